stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Parametrised successor to the combinational 1-to-4 single-bit demux: width, channel count and broadcast mode are generalised.
- Sits between a single producer and N independent consumers.
- One-entry holding register per channel, so one stalled sink does not block traffic to the other sinks.
- Saturating error counter for out-of-range selects.

Parameters:
- N, 4, number of output channels (2..16, need not be a power of two).
- W, 8, data width per channel.
- SEL_W, $clog2(N), width of the select field (minimum 1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block accepts the beat this cycle.
- in_sel  in  SEL_W  target channel index.
- in_data  in  W  payload.
- bcast  in  1  1 = copy the beat to all channels; in_sel is ignored.
- out_valid  out  N  per-channel valid.
- out_ready  in  N  per-channel sink ready.
- out_data  out  N*W  channel i occupies bits [i*W +: W].
- err_cnt  out  ERR_W  count of dropped out-of-range beats.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, out_data = 0, err_cnt = 0.
- in_ready is combinational from bcast, in_sel, out_valid and out_ready, and never depends on in_valid.
- Slot i is free when !out_valid[i] || out_ready[i]. This pass-through ready gives full throughput.
- Ready rules:
  - bcast = 1: in_ready = AND of free over all i.
  - bcast = 0 and in_sel < N: in_ready = free[in_sel].
  - bcast = 0 and in_sel >= N: in_ready = 1.
- Accept means in_valid && in_ready at a rising edge.
- Latency: a beat accepted at edge k is visible on out_valid/out_data from edge k onward (one register stage).
- Slot update at each edge, for channel i:
  - Load (out_valid[i] = 1, out_data[i] = in_data) if accept && (bcast || in_sel == i).
  - Else clear out_valid[i] if out_ready[i]; out_data holds its last value.
  - Else hold.
- Simultaneous drain and load on the same channel: the load wins; the old beat is consumed and the new beat is presented.
- Stable output: while out_valid[i] && !out_ready[i], out_data[i] must not change.
- Broadcast accepts only when every slot is free, then loads all N slots on the same edge. No partial broadcasts.
- Out-of-range select (bcast = 0, in_sel >= N, including non-power-of-two N):
  - The beat is accepted and dropped; no slot changes.
  - err_cnt increments by 1 and saturates at 2^ERR_W-1.
- Clearing: err_cnt clears only on reset.
- Mode and select are sampled only at accept. Changing bcast or in_sel while in_valid is low has no effect.
- Reset asserted mid-transfer: all slots clear immediately and in-flight beats are lost. No output toggles during reset.
- Independence: a stalled channel blocks only beats addressed to that channel, or broadcasts.

Decomposition:
- Package stream_demux_pkg holds:
  - the default N/W/ERR_W constants;
  - the sel_w function (clog2 with minimum 1);
  - a localparam for the err_cnt saturation value.
- Sub-module demux_slot: one-entry W-bit holding register.
  - Ports: clk, rst_n, load, load_data, drain, valid, data, free.
  - Instantiated N times via generate.
- Top level holds the select decode, the in_ready reduction and the error counter.

Test Plan:
- Basic routing, N=4, W=8, all out_ready=1: beats (sel 0..3, data 8'hA0..8'hA3) on consecutive cycles -> each out_valid[i] pulses one cycle after its accept with out_data[i] = 8'hA0+i; in_ready stays 1 throughout; err_cnt = 0.
- Backpressure isolation: out_ready[2] = 0, send sel 2 (8'h55), then sel 2 (8'h66), then sel 1 (8'h77) -> 8'h55 is held stable on channel 2; in_ready = 0 for the second sel-2 beat; when the producer reorders, sel 1 is accepted immediately; raising out_ready[2] drains 8'h55 and 8'h66 is then accepted.
- Drain and load on the same edge: channel 0 holds 8'h11 with out_ready[0] = 1; send sel 0 (8'h22) -> out_data[0] = 8'h22 the next cycle with no bubble; 8'h11 is consumed exactly once.
- Broadcast: bcast = 1, data 8'hBC with out_valid[3] = 1 and out_ready[3] = 0 -> in_ready = 0 and no slot loads; release out_ready[3] -> all four channels show 8'hBC on the same cycle.
- Out-of-range select and saturation, N=3: 300 beats with sel = 3 -> in_ready = 1, no out_valid ever asserts, err_cnt saturates at 255.
- Async reset mid-stream: assert rst_n = 0 between edges with slots full -> out_valid = 0, out_data = 0 and err_cnt = 0 immediately, without waiting for a clock edge; the first beat after release routes correctly.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared defaults, select-width helper and route classification for stream_demux.
package stream_demux_pkg;

  localparam int unsigned N_DEFAULT     = 4;
  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned ERR_W_DEFAULT = 8;

  localparam logic [ERR_W_DEFAULT-1:0] ERR_SAT = '1;

  typedef enum logic [1:0] {
    ROUTE_CHAN,
    ROUTE_BCAST,
    ROUTE_DROP
  } route_e;

  // Select field is never narrower than one bit, even for N = 2.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  // A slot being drained this cycle can accept a new beat on the same edge.
  assign free = !valid || drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N valid/ready stream demultiplexer with broadcast mode and
// a saturating counter of beats dropped for out-of-range selects.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned SEL_W = sel_w(N),
  parameter int unsigned ERR_W = ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [W-1:0]     in_data,
  input  logic             bcast,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*W-1:0]   out_data,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [N-1:0] free;
  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  route_e       route;
  logic         accept;

  always_comb begin
    sel_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_hit[i] = (in_sel == SEL_W'(i));
    end
  end

  always_comb begin
    route = ROUTE_CHAN;
    if (bcast) begin
      route = ROUTE_BCAST;
    end else if ({1'b0, in_sel} >= N_EXT) begin
      route = ROUTE_DROP;
    end
  end

  // Ready never looks at in_valid; out-of-range beats are always swallowed.
  always_comb begin
    in_ready = 1'b1;
    case (route)
      ROUTE_BCAST: in_ready = &free;
      ROUTE_CHAN:  in_ready = |(sel_hit & free);
      ROUTE_DROP:  in_ready = 1'b1;
      default:     in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      case (route)
        ROUTE_BCAST: load = '1;
        ROUTE_CHAN:  load = sel_hit;
        default:     load = '0;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(
      .W(W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .drain     (out_ready[g]),
      .valid     (out_valid[g]),
      .data      (out_data[g*W +: W]),
      .free      (free[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && (route == ROUTE_DROP) && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: N=4 instance with a per-beat scoreboard, N=3
// instance for out-of-range drops and counter saturation.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = '0;
  logic [7:0]  in_data = '0;
  logic        bcast = 1'b0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [1:0]  in_sel3 = '0;
  logic [7:0]  in_data3 = '0;
  logic        bcast3 = 1'b0;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = '1;
  logic [23:0] out_data3;
  logic [7:0]  err_cnt3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string      name;
    logic       v;
    logic       b;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       exp_in_ready;
    logic [3:0] exp_ov;
  } vec_t;

  always #5 clk = ~clk;

  stream_demux #(.N(4), .W(8), .SEL_W(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .bcast(bcast), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_cnt(err_cnt)
  );

  stream_demux #(.N(3), .W(8), .SEL_W(2), .ERR_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_sel(in_sel3), .in_data(in_data3), .bcast(bcast3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .err_cnt(err_cnt3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check ready, retire handshakes against the scoreboard,
  // enqueue the accepted beat, then check out_valid after the edge.
  task automatic step(input vec_t t);
    int idx;
    @(negedge clk);
    in_valid  = t.v;
    bcast     = t.b;
    in_sel    = t.sel;
    in_data   = t.d;
    out_ready = t.rdy;
    #1;
    chk({t.name, " in_ready"}, {31'd0, in_ready}, {31'd0, t.exp_in_ready});
    for (int ch = 0; ch < 4; ch++) begin
      if (out_valid[ch] && out_ready[ch]) begin
        idx = -1;
        for (int k = 0; k < sbq.size(); k++) begin
          if (sbq[k].ch == 2'(ch)) begin
            idx = k;
            break;
          end
        end
        total++;
        if (idx < 0) begin
          bad++;
          $display("FAIL %s ch%0d: got unexpected beat %0h, expected none", t.name, ch, out_data[ch*8 +: 8]);
        end else begin
          total--;
          chk($sformatf("%s ch%0d data", t.name, ch), {24'd0, out_data[ch*8 +: 8]}, {24'd0, sbq[idx].d});
          sbq.delete(idx);
        end
      end
    end
    if (in_valid && in_ready) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (bcast || in_sel == 2'(ch)) sbq.push_back('{ch: 2'(ch), d: in_data});
      end
    end
    @(posedge clk);
    #1;
    chk({t.name, " out_valid"}, {28'd0, out_valid}, {28'd0, t.exp_ov});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    #2;
    chk("reset out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("reset out_valid3", {29'd0, out_valid3}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    tbl = '{
      '{"route0", 1'b1, 1'b0, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001},
      '{"route1", 1'b1, 1'b0, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010},
      '{"route2", 1'b1, 1'b0, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100},
      '{"route3", 1'b1, 1'b0, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000},
      '{"idle",   1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000},
      '{"bp55",   1'b1, 1'b0, 2'd2, 8'h55, 4'b1011, 1'b1, 4'b0100},
      '{"bp66",   1'b1, 1'b0, 2'd2, 8'h66, 4'b1011, 1'b0, 4'b0100},
      '{"bp77",   1'b1, 1'b0, 2'd1, 8'h77, 4'b1011, 1'b1, 4'b0110},
      '{"bp66b",  1'b1, 1'b0, 2'd2, 8'h66, 4'b1111, 1'b1, 4'b0100},
      '{"bpidle", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000},
      '{"dl11",   1'b1, 1'b0, 2'd0, 8'h11, 4'b1111, 1'b1, 4'b0001},
      '{"dl22",   1'b1, 1'b0, 2'd0, 8'h22, 4'b1111, 1'b1, 4'b0001}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      if (tbl[i].name == "bp66") chk("bp hold ch2", {24'd0, out_data[23:16]}, 32'h55);
      if (tbl[i].name == "dl22") chk("dl no bubble ch0", {24'd0, out_data[7:0]}, 32'h22);
    end
    v = '{"dlidle", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000};
    step(v);
    chk("route err_cnt", {24'd0, err_cnt}, 32'd0);

    // Broadcast blocked by one stalled slot, then released.
    v = '{"bc fill3", 1'b1, 1'b0, 2'd3, 8'h33, 4'b0111, 1'b1, 4'b1000};
    step(v);
    v = '{"bc stall", 1'b1, 1'b1, 2'd0, 8'hBC, 4'b0111, 1'b0, 4'b1000};
    step(v);
    chk("bc stall ch3", {24'd0, out_data[31:24]}, 32'h33);
    v = '{"bc go", 1'b1, 1'b1, 2'd0, 8'hBC, 4'b1111, 1'b1, 4'b1111};
    step(v);
    chk("bc all data", out_data, 32'hBCBCBCBC);
    v = '{"bc idle", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000};
    step(v);

    // N=3: select 3 is out of range; every beat is swallowed and counted.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid3 = 1'b1;
      bcast3    = 1'b0;
      in_sel3   = 2'd3;
      in_data3  = 8'(i);
      #1;
      chk("oor in_ready", {31'd0, in_ready3}, 32'd1);
      @(posedge clk);
      #1;
      chk("oor out_valid", {29'd0, out_valid3}, 32'd0);
      if (i == 99)  chk("oor err 100", {24'd0, err_cnt3}, 32'd100);
      if (i == 254) chk("oor err 255", {24'd0, err_cnt3}, 32'd255);
    end
    chk("oor err sat", {24'd0, err_cnt3}, 32'd255);
    @(negedge clk);
    in_valid3 = 1'b1;
    in_sel3   = 2'd2;
    in_data3  = 8'h5A;
    out_ready3 = 3'b000;
    @(posedge clk);
    #1;
    chk("n3 route ov", {29'd0, out_valid3}, 32'b100);
    chk("n3 route data", {8'd0, out_data3}, 32'h5A0000);
    @(negedge clk);
    in_valid3 = 1'b0;
    in_sel3   = 2'd3;
    out_ready3 = 3'b111;
    @(posedge clk);
    #1;
    chk("n3 idle ov", {29'd0, out_valid3}, 32'd0);

    // Async reset between edges with every slot full.
    v = '{"rst fill", 1'b1, 1'b1, 2'd0, 8'hE7, 4'b0000, 1'b1, 4'b1111};
    step(v);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {28'd0, out_valid}, 32'd0);
    chk("async rst out_data", out_data, 32'd0);
    chk("async rst err_cnt3", {24'd0, err_cnt3}, 32'd0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{"post rst", 1'b1, 1'b0, 2'd1, 8'hC1, 4'b1111, 1'b1, 4'b0010};
    step(v);
    chk("post rst data", {24'd0, out_data[15:8]}, 32'hC1);
    v = '{"post idle", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000};
    step(v);
    chk("scoreboard empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
